// File: rtl/gate_sweep_controller_pkg.sv
// rtl/gate_sweep_controller_pkg.sv - shared state encoding, truth tables and widths for the gate sweep controller
package gate_sweep_controller_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t DRIVE  = 3'd1;
  localparam state_t SETTLE = 3'd2;
  localparam state_t SAMPLE = 3'd3;
  localparam state_t DONE   = 3'd4;

  // bit i = expected y for {a,b} = i
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  localparam int SETTLE_W   = 4;
  localparam int ERR_W      = 3;
  localparam int NUM_COMBOS = 4;

  function automatic logic expected_y(input logic [NUM_COMBOS-1:0] tt, input logic [1:0] idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/gate_sweep_controller_if.sv
// rtl/gate_sweep_controller_if.sv - run control, gate pins and result signals of the gate sweep controller
//   start     : run request (in to controller)
//   gate_a/b  : gate inputs driven by the controller
//   gate_y    : gate output under check (in to controller)
//   busy/done : sweep in progress / one-cycle completion pulse
//   pass, err_count, fail_vec : results of the last completed sweep
interface gate_sweep_controller_if;
  import gate_sweep_controller_pkg::*;

  logic                  start;
  logic                  gate_a;
  logic                  gate_b;
  logic                  gate_y;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ERR_W-1:0]      err_count;
  logic [NUM_COMBOS-1:0] fail_vec;

  modport master (
    input  start, gate_y,
    output gate_a, gate_b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, gate_y,
    input  gate_a, gate_b, busy, done, pass, err_count, fail_vec
  );

endinterface

// File: rtl/gate_sweep_controller.sv
// rtl/gate_sweep_controller.sv - steps a 2-input gate through all input combinations and checks its output
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : master side of gate_sweep_controller_if (start in, gate pins, status and results out)
module gate_sweep_controller
  import gate_sweep_controller_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_OR,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gate_sweep_controller_if.master bus
);

  // The counter counts down to zero inclusive, so it is loaded with one less
  // than the number of settle cycles.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
    SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            idx;
  logic [1:0]            gate_ab;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [ERR_W-1:0]      err_count;
  logic [ERR_W-1:0]      err_nxt;
  logic [NUM_COMBOS-1:0] fail_vec;
  logic                  pass;
  logic                  mismatch;
  logic                  busy_c;
  logic                  done_c;

  assign mismatch = (bus.gate_y != expected_y(TRUTH_TABLE, idx));
  assign err_nxt  = err_count + {{(ERR_W-1){1'b0}}, mismatch};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = DRIVE;
      DRIVE:   state_nxt = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == 2'd3) ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      DRIVE, SETTLE, SAMPLE: busy_c = 1'b1;
      DONE:                  done_c = 1'b1;
      default:               ;
    endcase
  end

  // sweep datapath: combination index, gate pins, settle counter and results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 2'd0;
      gate_ab    <= 2'b00;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_vec   <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx       <= 2'd0;
            gate_ab   <= 2'b00;
            err_count <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
          end
        end
        DRIVE: begin
          if (SETTLE_CYCLES > 0) settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        SAMPLE: begin
          err_count <= err_nxt;
          if (mismatch) fail_vec[idx] <= 1'b1;
          if (idx == 2'd3) begin
            // pass is settled on the edge entering DONE so it is valid with the done pulse
            pass <= (err_nxt == '0);
          end else begin
            idx     <= idx + 2'd1;
            gate_ab <= idx + 2'd1;
          end
        end
        DONE: begin
          gate_ab <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign bus.gate_a    = gate_ab[1];
  assign bus.gate_b    = gate_ab[0];
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.pass      = pass;
  assign bus.err_count = err_count;
  assign bus.fail_vec  = fail_vec;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// tb/tb_gate_sweep_controller.sv - scoreboard bench for gate_sweep_controller with a behavioural sweep model
module tb_gate_sweep_controller;
  import gate_sweep_controller_pkg::*;

  localparam int S_A = 2;
  localparam int S_B = 0;
  localparam logic [3:0] TT_A = TT_OR;
  localparam logic [3:0] TT_B = TT_AND;
  localparam int MAX_WAIT = 400;

  typedef struct {
    int         done_edge;
    logic       pass;
    logic [2:0] err;
    logic [3:0] fv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] fn [2];
  int         acc [2];
  bit         active [2];
  int         free_edge [2];
  exp_t       hold [2];
  exp_t       q0 [$];
  exp_t       q1 [$];

  logic [1:0] ab_v   [2];
  logic       busy_v [2];
  logic       done_v [2];
  logic       pass_v [2];
  logic [2:0] err_v  [2];
  logic [3:0] fv_v   [2];

  gate_sweep_controller_if if_a ();
  gate_sweep_controller_if if_b ();

  gate_sweep_controller #(.TRUTH_TABLE(TT_A), .SETTLE_CYCLES(S_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  gate_sweep_controller #(.TRUTH_TABLE(TT_B), .SETTLE_CYCLES(S_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  // gate under check: any 2-input function given by its 4-entry table
  assign if_a.gate_y = fn[0][{if_a.gate_a, if_a.gate_b}];
  assign if_b.gate_y = fn[1][{if_b.gate_a, if_b.gate_b}];

  assign ab_v[0] = {if_a.gate_a, if_a.gate_b};
  assign ab_v[1] = {if_b.gate_a, if_b.gate_b};
  assign busy_v[0] = if_a.busy;
  assign busy_v[1] = if_b.busy;
  assign done_v[0] = if_a.done;
  assign done_v[1] = if_b.done;
  assign pass_v[0] = if_a.pass;
  assign pass_v[1] = if_b.pass;
  assign err_v[0]  = if_a.err_count;
  assign err_v[1]  = if_b.err_count;
  assign fv_v[0]   = if_a.fail_vec;
  assign fv_v[1]   = if_b.fail_vec;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int per_combo(input int d);
    return ((d == 0) ? S_A : S_B) + 2;
  endfunction

  function automatic int sweep_len(input int d);
    return 4 * per_combo(d);
  endfunction

  function automatic exp_t zero_exp();
    exp_t z;
    z.done_edge = 0;
    z.pass = 1'b0;
    z.err = 3'd0;
    z.fv = 4'd0;
    return z;
  endfunction

  // expected results: every combination where the gate disagrees with the table is a mismatch
  function automatic exp_t model(input int d, input logic [3:0] g, input int done_edge);
    exp_t e;
    logic [3:0] tt;
    int n;
    tt = (d == 0) ? TT_A : TT_B;
    n = 0;
    for (int i = 0; i < 4; i++) if (g[i] != tt[i]) n++;
    e.done_edge = done_edge;
    e.fv = g ^ tt;
    e.err = 3'(n);
    e.pass = (n == 0);
    return e;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s dut%0d @cycle %0d: got %0d, required %0d", name, d, cyc, act, expv);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) if_a.start = v;
    else        if_b.start = v;
  endtask

  // Hold start high for n_high edges; the model accepts only on edges where the DUT is idle.
  task automatic drive_start(input int d, input logic [3:0] g, input int n_high);
    int e;
    for (int i = 0; i < n_high; i++) begin
      @(negedge clk);
      e = cyc + 1;
      if (e >= free_edge[d]) begin
        fn[d] = g;
        acc[d] = e;
        active[d] = 1'b1;
        free_edge[d] = e + sweep_len(d) + 2;
        if (d == 0) q0.push_back(model(d, g, e + sweep_len(d)));
        else        q1.push_back(model(d, g, e + sweep_len(d)));
      end
      set_start(d, 1'b1);
    end
    @(negedge clk);
    set_start(d, 1'b0);
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", d, (n >= MAX_WAIT) ? 1 : 0, 0);
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, busy_v[d], 0);
      chk("rst_done", d, done_v[d], 0);
      chk("rst_gate_ab", d, ab_v[d], 0);
      chk("rst_pass", d, pass_v[d], 0);
      chk("rst_err_count", d, err_v[d], 0);
      chk("rst_fail_vec", d, fv_v[d], 0);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      active[d] = 1'b0;
      free_edge[d] = 0;
      hold[d] = zero_exp();
    end
    q0.delete();
    q1.delete();
  endtask

  // monitor: one step per cycle, #1 after the rising edge
  initial begin
    exp_t e;
    bit   have;
    int   per;
    int   len;
    int   k;
    int   ab_exp;
    bit   busy_exp;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        per = per_combo(d);
        len = sweep_len(d);
        k = cyc - acc[d];
        have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
        e = zero_exp();
        if (have) begin
          if (d == 0) e = q0[0];
          else        e = q1[0];
        end
        if (done_v[d]) begin
          if (!have) begin
            chk("unexpected_done", d, 1, 0);
          end else begin
            chk("done_cycle", d, cyc, e.done_edge);
            chk("pass", d, e.pass == pass_v[d] ? e.pass : pass_v[d], e.pass);
            chk("err_count", d, err_v[d], e.err);
            chk("fail_vec", d, fv_v[d], e.fv);
            hold[d] = e;
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end else if (have && cyc > e.done_edge) begin
          chk("missing_done", d, 0, 1);
          if (d == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
        busy_exp = active[d] && k >= 0 && k < len;
        chk("busy", d, busy_v[d], busy_exp);
        if (active[d] && k >= 0 && k <= len) ab_exp = (k / per > 3) ? 3 : k / per;
        else                                 ab_exp = 0;
        chk("gate_ab", d, ab_v[d], ab_exp);
        if (!busy_exp) begin
          chk("hold_pass", d, pass_v[d], hold[d].pass);
          chk("hold_err_count", d, err_v[d], hold[d].err);
          chk("hold_fail_vec", d, fv_v[d], hold[d].fv);
        end
      end
    end
  end

  initial begin
    int n;
    int d;
    logic [3:0] g;
    rst_n = 1'b1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    fn[0] = TT_OR;
    fn[1] = TT_AND;
    for (int i = 0; i < 2; i++) acc[i] = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // OR gate against OR table, default settle
    drive_start(0, TT_OR, 1);
    wait_drain(0);
    // gate output stuck at 0
    drive_start(0, 4'b0000, 1);
    wait_drain(0);
    // AND gate against OR table
    drive_start(0, TT_AND, 1);
    wait_drain(0);
    // zero-settle build with AND table; a start mid-sweep must be ignored
    drive_start(1, TT_AND, 1);
    repeat (3) @(negedge clk);
    drive_start(1, TT_AND, 1);
    wait_drain(1);
    drive_start(1, TT_OR, 1);
    wait_drain(1);
    // start held high: back-to-back sweeps
    drive_start(0, TT_OR, 40);
    wait_drain(0);
    drive_start(1, TT_XOR, 40);
    wait_drain(1);

    // reset during SETTLE of combination 2
    drive_start(0, TT_OR, 1);
    n = 0;
    while (cyc != acc[0] + 9 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_settle_idx2", 0, (n >= 50) ? 1 : 0, 0);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_start(0, TT_OR, 1);
    wait_drain(0);

    // randomized gates, start widths and gaps on both builds
    repeat (30) begin
      d = int'($urandom_range(0, 1));
      g = 4'($urandom_range(0, 15));
      drive_start(d, g, int'($urandom_range(1, 4)));
      repeat (int'($urandom_range(0, 20))) @(negedge clk);
    end
    wait_drain(0);
    wait_drain(1);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
